// File: rtl/fft_capture_pkg.sv
// Shared types and width helpers for the FFT frame capture block.
package fft_capture_pkg;

    typedef enum logic [1:0] {
        WR_IDLE       = 2'd0,
        WR_WAIT_SPACE = 2'd1,
        WR_FILL       = 2'd2
    } wr_state_e;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    function automatic int frame_cnt_w(input int frame_len);
        return $clog2(frame_len);
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy count.
// Read data updates only on an accepted read; writes to a full FIFO are dropped.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [W-1:0]           i_wr_dat,
    input  logic                   i_rd_en,
    output logic [W-1:0]           o_rd_dat,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_rd_dat;
    logic          w_wr;
    logic          w_rd;

    assign w_wr     = i_wr_en && (r_count != DEPTH_C);
    assign w_rd     = i_rd_en && (r_count != '0);
    assign o_rd_dat = r_rd_dat;
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rd_dat <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_rd_dat <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_capture.sv
// Captures whole frames of a never-stalling sample stream into a FIFO and replays them as AXIS with tlast.
// Space for a full frame is reserved before filling, so input is never back-pressured; skipped frames are counted.
module fft_frame_capture
    import fft_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  arm,
    input  logic                  continuous,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frames_dropped
);

    localparam int FW = frame_cnt_w(FRAME_LEN);
    localparam int CW = fifo_cnt_w(FIFO_DEPTH);
    localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FRAME_C  = CW'(FRAME_LEN);

    wr_state_e       r_state;
    wr_state_e       w_next;
    logic            r_armed;
    logic            r_busy;
    logic            r_sready;
    logic            r_tvalid;
    logic            r_frame_done;
    logic [FW-1:0]   r_wr_cnt;
    logic [FW-1:0]   r_rd_cnt;
    logic [FW-1:0]   r_skip_cnt;
    logic [15:0]     r_dropped;

    logic [CW-1:0]         w_count;
    logic [DATA_WIDTH-1:0] w_fifo_dat;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_skip;
    logic                  w_room;
    logic                  w_arm_ok;
    logic                  w_hs;
    logic                  w_tlast;
    logic                  w_busy_clr;

    sync_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_wr_en),
        .i_wr_dat (s_axis_tdata),
        .i_rd_en  (w_rd_en),
        .o_rd_dat (w_fifo_dat),
        .o_count  (w_count)
    );

    assign w_room   = (DEPTH_C - w_count) >= FRAME_C;
    assign w_arm_ok = arm && !r_busy;

    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_skip  = 1'b0;
        case (r_state)
            WR_IDLE: begin
                if (continuous || w_arm_ok) begin
                    w_next = WR_WAIT_SPACE;
                end
            end
            WR_WAIT_SPACE: begin
                // A dropped continuous request with no pending one-shot abandons the wait.
                if (!(continuous || r_armed)) begin
                    w_next = WR_IDLE;
                end else if (w_room) begin
                    w_next = WR_FILL;
                end else begin
                    w_skip = s_axis_tvalid && continuous;
                end
            end
            WR_FILL: begin
                w_wr_en = s_axis_tvalid;
                if (s_axis_tvalid && (r_wr_cnt == LAST_IDX)) begin
                    w_next = continuous ? WR_WAIT_SPACE : WR_IDLE;
                end
            end
            default: w_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= WR_IDLE;
            r_armed  <= 1'b0;
            r_wr_cnt <= '0;
            r_sready <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_sready <= 1'b1;
            if (r_state == WR_IDLE && w_arm_ok && !continuous) begin
                r_armed <= 1'b1;
            end else if (r_state == WR_WAIT_SPACE && w_next == WR_FILL) begin
                r_armed <= 1'b0;
            end
            if (r_state == WR_FILL) begin
                if (w_wr_en) begin
                    r_wr_cnt <= r_wr_cnt + FW'(1);
                end
            end else begin
                r_wr_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_cnt <= '0;
            r_dropped  <= '0;
        end else if (r_state != WR_WAIT_SPACE) begin
            r_skip_cnt <= '0;
        end else if (w_skip) begin
            r_skip_cnt <= r_skip_cnt + FW'(1);
            if (r_skip_cnt == LAST_IDX && r_dropped != DROP_SAT) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    // The FIFO read register doubles as the AXIS output stage.
    assign w_rd_en = (w_count != '0) && (!r_tvalid || m_axis_tready);
    assign w_hs    = r_tvalid && m_axis_tready;
    assign w_tlast = r_tvalid && (r_rd_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid     <= 1'b0;
            r_rd_cnt     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_hs) begin
                r_rd_cnt <= r_rd_cnt + FW'(1);
            end
            r_frame_done <= w_hs && w_tlast;
        end
    end

    assign w_busy_clr = (r_state == WR_IDLE) && (w_count == '0) &&
                        (!r_tvalid || (w_hs && w_tlast));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (r_state == WR_IDLE && w_next != WR_IDLE) begin
            r_busy <= 1'b1;
        end else if (w_busy_clr) begin
            r_busy <= 1'b0;
        end
    end

    assign s_axis_tready  = r_sready;
    assign m_axis_tdata   = w_fifo_dat;
    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tlast   = w_tlast;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
    assign frames_dropped = r_dropped;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Scoreboard bench for fft_frame_capture with FRAME_LEN=8, FIFO_DEPTH=16.
module tb_fft_frame_capture;

    localparam int DW = 16;
    localparam int FL = 8;
    localparam int FD = 16;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          arm = 1'b0;
    logic          continuous = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frames_dropped;

    int    checks = 0;
    int    failures = 0;
    int    frames_seen = 0;
    int    fd_cnt = 0;
    int    tr_mode = 2;
    beat_t exp_q[$];
    beat_t exp_b;
    logic          prev_stall = 1'b0;
    logic          prev_last_hs = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic          prev_lst = 1'b0;

    fft_frame_capture #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .arm            (arm),
        .continuous     (continuous),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
        .frame_done     (frame_done),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base);
        beat_t b;
        for (int i = 0; i < FL; i++) begin
            b.dat  = DW'(base + i);
            b.last = (i == FL - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic feed(input int base, input int n, input logic [63:0] arm_mask,
                        input bit cont, input int cont_off);
        for (int k = 0; k < n; k++) begin
            s_axis_tdata  = DW'(base + k);
            s_axis_tvalid = 1'b1;
            arm           = arm_mask[k];
            continuous    = cont && (cont_off < 0 || k < cont_off);
            tick();
        end
        s_axis_tvalid = 1'b0;
        arm           = 1'b0;
        continuous    = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy || m_axis_tvalid) && t < 300) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL %s drain_timeout pending=%0d busy=%0b required pending=0 busy=0",
                     nm, exp_q.size(), busy);
        end
        repeat (4) tick();
    endtask

    // Back-pressure pattern generator
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            tick();
            case (tr_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: output beats against the scoreboard, stall stability, frame_done alignment
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            chk("frame_done_align", {31'd0, frame_done}, {31'd0, prev_last_hs});
            if (frame_done) fd_cnt++;
            if (prev_stall) begin
                chk("stall_hold", {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {14'd0, 1'b1, prev_lst, prev_dat});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h/last=%0b required=no_beat",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== {exp_b.last, exp_b.dat}) begin
                        failures++;
                        $display("FAIL beat actual=%0h/last=%0b required=%0h/last=%0b",
                                 m_axis_tdata, m_axis_tlast, exp_b.dat, exp_b.last);
                    end
                end
                if (m_axis_tlast) frames_seen++;
            end
            prev_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            prev_stall   = m_axis_tvalid && !m_axis_tready;
            prev_dat     = m_axis_tdata;
            prev_lst     = m_axis_tlast;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int d0;
        repeat (3) tick();
        chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("rst_m_tdata", {16'd0, m_axis_tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_dropped", {16'd0, frames_dropped}, 32'd0);
        rst = 1'b0;
        tick();
        chk("s_tready_after_rst", {31'd0, s_axis_tready}, 32'd1);

        // 1: one-shot, free-flowing output
        tr_mode = 0; tick();
        f0 = frames_seen; d0 = fd_cnt;
        push_frame(2);
        feed(0, 20, 64'h1, 1'b0, -1);
        wait_idle("t1");
        chk("t1_frames", frames_seen - f0, 32'd1);
        chk("t1_frame_done", fd_cnt - d0, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: one-shot with alternating back-pressure
        tr_mode = 1; tick();
        f0 = frames_seen;
        push_frame(22);
        feed(20, 20, 64'h1, 1'b0, -1);
        wait_idle("t2");
        chk("t2_frames", frames_seen - f0, 32'd1);

        // 3: continuous with output stalled; two frames fit, the rest is dropped
        tr_mode = 2; tick();
        f0 = frames_seen; d0 = fd_cnt;
        push_frame(42);
        push_frame(51);
        feed(40, 40, 64'h0, 1'b1, -1);
        repeat (3) tick();
        chk("t3_dropped", {16'd0, frames_dropped}, 32'd2);
        chk("t3_busy_stalled", {31'd0, busy}, 32'd1);
        tr_mode = 0;
        wait_idle("t3");
        chk("t3_frames", frames_seen - f0, 32'd2);
        chk("t3_frame_done", fd_cnt - d0, 32'd2);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // 4: continuous dropped after three writes
        f0 = frames_seen;
        push_frame(102);
        feed(100, 20, 64'h0, 1'b1, 5);
        wait_idle("t4");
        chk("t4_frames", frames_seen - f0, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);

        // 6: arm re-pulsed mid-fill and while draining
        f0 = frames_seen;
        push_frame(202);
        feed(200, 20, 64'h421, 1'b0, -1);
        wait_idle("t6");
        chk("t6_frames", frames_seen - f0, 32'd1);

        // 5: reset after five writes, then a clean frame
        tr_mode = 2; tick();
        feed(300, 7, 64'h1, 1'b0, -1);
        chk("t5_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'd307;
        tick();
        chk("t5_s_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("t5_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t5_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("t5_m_tdata", {16'd0, m_axis_tdata}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_frame_done", {31'd0, frame_done}, 32'd0);
        chk("t5_dropped", {16'd0, frames_dropped}, 32'd0);
        tick();
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        chk("t5_s_tready_after", {31'd0, s_axis_tready}, 32'd1);
        tr_mode = 1; tick();
        f0 = frames_seen;
        push_frame(402);
        feed(400, 20, 64'h1, 1'b0, -1);
        wait_idle("t5");
        chk("t5_frames", frames_seen - f0, 32'd1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
